// File: rtl/deck_dealer.sv
// Card source for the blackjack controller: fills a small deck from a seeded 8-bit LFSR
// using rejection sampling, then deals one card per request until the deck runs out.
module deck_dealer #(
    parameter int          DECK_SIZE    = 12,
    parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [7:0] seed,
    input  logic       shuffle_start,
    input  logic       deal_req,
    output logic [3:0] card_out,
    output logic       card_is_ace,
    output logic       card_valid,
    output logic       deck_ready,
    output logic       deck_empty,
    output logic       busy,
    output logic [3:0] cards_left
);

    localparam logic [3:0] LAST_IDX  = 4'(DECK_SIZE - 1);
    localparam logic [3:0] DECK_CNT  = 4'(DECK_SIZE);

    typedef enum logic [1:0] {IDLE, FILL, READY, EMPTY} state_t;

    state_t     state_reg;
    logic [7:0] lfsr_reg;
    logic [3:0] wr_ptr_reg;
    logic [3:0] rd_ptr_reg;
    logic [3:0] card_out_reg;
    logic       card_is_ace_reg;
    logic       card_valid_reg;
    logic       deck_ready_reg;
    logic       deck_empty_reg;
    logic       busy_reg;
    logic [3:0] cards_left_reg;

    logic [3:0] deck_mem [DECK_SIZE];
    logic       ace_mem  [DECK_SIZE];

    logic [7:0] lfsr_next;
    logic [7:0] seed_eff;
    logic [3:0] nib;
    logic       sample_ok;
    logic [3:0] sample_val;
    logic       sample_ace;

    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    // An all-zero LFSR would lock up, so a zero seed is nudged to 1.
    assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
    assign nib       = lfsr_reg[3:0];
    assign sample_ok = (nib < 4'd13);

    always_comb begin
        sample_val = 4'd10;
        sample_ace = 1'b0;
        if (nib == 4'd0) begin
            sample_val = 4'd1;
            sample_ace = 1'b1;
        end else if (nib <= 4'd9) begin
            sample_val = nib + 4'd1;
        end
    end

    // Deck storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == FILL && sample_ok) begin
            deck_mem[wr_ptr_reg] <= sample_val;
            ace_mem[wr_ptr_reg]  <= sample_ace;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lfsr_reg        <= SEED_DEFAULT;
            wr_ptr_reg      <= 4'd0;
            rd_ptr_reg      <= 4'd0;
            card_out_reg    <= 4'd0;
            card_is_ace_reg <= 1'b0;
            card_valid_reg  <= 1'b0;
            deck_ready_reg  <= 1'b0;
            deck_empty_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            cards_left_reg  <= 4'd0;
        end else begin
            card_valid_reg <= 1'b0;
            case (state_reg)
                IDLE, READY, EMPTY: begin
                    if (seed_load) begin
                        lfsr_reg <= seed_eff;
                    end
                    // A shuffle request wins over a deal arriving in the same cycle.
                    if (shuffle_start) begin
                        state_reg      <= FILL;
                        wr_ptr_reg     <= 4'd0;
                        rd_ptr_reg     <= 4'd0;
                        busy_reg       <= 1'b1;
                        deck_ready_reg <= 1'b0;
                        deck_empty_reg <= 1'b0;
                        cards_left_reg <= 4'd0;
                    end else if (state_reg == READY && deal_req) begin
                        card_valid_reg  <= 1'b1;
                        card_out_reg    <= deck_mem[rd_ptr_reg];
                        card_is_ace_reg <= ace_mem[rd_ptr_reg];
                        rd_ptr_reg      <= rd_ptr_reg + 4'd1;
                        if (rd_ptr_reg == LAST_IDX) begin
                            state_reg      <= EMPTY;
                            deck_ready_reg <= 1'b0;
                            deck_empty_reg <= 1'b1;
                            cards_left_reg <= 4'd0;
                        end else begin
                            cards_left_reg <= DECK_CNT - rd_ptr_reg - 4'd1;
                        end
                    end
                end
                FILL: begin
                    lfsr_reg <= lfsr_next;
                    if (sample_ok) begin
                        wr_ptr_reg <= wr_ptr_reg + 4'd1;
                        if (wr_ptr_reg == LAST_IDX) begin
                            state_reg      <= READY;
                            busy_reg       <= 1'b0;
                            deck_ready_reg <= 1'b1;
                            cards_left_reg <= DECK_CNT;
                        end
                    end
                end
            endcase
        end
    end

    assign card_out    = card_out_reg;
    assign card_is_ace = card_is_ace_reg;
    assign card_valid  = card_valid_reg;
    assign deck_ready  = deck_ready_reg;
    assign deck_empty  = deck_empty_reg;
    assign busy        = busy_reg;
    assign cards_left  = cards_left_reg;

endmodule
